// File: rtl/nsa_pkg.sv
// nibble_serial_add_ctrl shared types and constants.
// Optional subtract support is enabled with NSA_SUB_EN.
package nsa_pkg;

  localparam int NSA_NIB_W       = 4;
  localparam int NSA_MAX_NIBBLES = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } nsa_state_e;

endpackage

// File: rtl/ripple_4bit.sv
// Existing 4-bit ripple-carry adder shared by the nibble sequencer.
// Port order is fixed as (cout, s, a, b, cin).
module ripple_4bit (
  output logic       cout,
  output logic [3:0] s,
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin
);

  logic cy;

  always_comb begin
    cy = cin;
    s  = '0;
    for (int i = 0; i < 4; i++) begin
      s[i] = a[i] ^ b[i] ^ cy;
      cy   = (a[i] & b[i]) | (cy & (a[i] ^ b[i]));
    end
    cout = cy;
  end

endmodule

// File: rtl/nibble_serial_add_ctrl.sv
// Wide adder sequenced one nibble per clock over a single ripple_4bit.
// Define NSA_SUB_EN to add the sub port (a - b via ~b + 1).
module nibble_serial_add_ctrl
  import nsa_pkg::*;
#(
  parameter int NIBBLES = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         start_valid,
  output logic                         start_ready,
  input  logic [NSA_NIB_W*NIBBLES-1:0] a,
  input  logic [NSA_NIB_W*NIBBLES-1:0] b,
  input  logic                         cin,
`ifdef NSA_SUB_EN
  input  logic                         sub,
`endif
  output logic                         res_valid,
  input  logic                         res_ready,
  output logic [NSA_NIB_W*NIBBLES-1:0] sum,
  output logic                         cout
);

  localparam int W  = NSA_NIB_W * NIBBLES;
  localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

  nsa_state_e state;

  logic [NIBBLES-1:0][NSA_NIB_W-1:0] a_q;
  logic [NIBBLES-1:0][NSA_NIB_W-1:0] b_q;
  logic [NIBBLES-1:0][NSA_NIB_W-1:0] sum_q;

  logic [IW-1:0] idx;
  logic          carry_q;

  logic [W-1:0]           b_in;
  logic                   c_in;
  logic [NSA_NIB_W-1:0]   nib_a;
  logic [NSA_NIB_W-1:0]   nib_b;
  logic [NSA_NIB_W-1:0]   nib_s;
  logic                   nib_co;

`ifdef NSA_SUB_EN
  // Two's complement subtract: invert b, force carry-in to 1.
  always_comb begin
    b_in = sub ? ~b : b;
    c_in = sub ? 1'b1 : cin;
  end
`else
  always_comb begin
    b_in = b;
    c_in = cin;
  end
`endif

  always_comb begin
    nib_a = '0;
    nib_b = '0;
    for (int i = 0; i < NIBBLES; i++) begin
      if (idx == IW'(i)) begin
        nib_a = a_q[i];
        nib_b = b_q[i];
      end
    end
  end

  ripple_4bit u_add (
    .cout (nib_co),
    .s    (nib_s),
    .a    (nib_a),
    .b    (nib_b),
    .cin  (carry_q)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      start_ready <= 1'b1;
      res_valid   <= 1'b0;
      cout        <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      sum_q       <= '0;
      idx         <= '0;
      carry_q     <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start_valid) begin
            a_q         <= a;
            b_q         <= b_in;
            carry_q     <= c_in;
            idx         <= '0;
            sum_q       <= '0;
            cout        <= 1'b0;
            start_ready <= 1'b0;
            state       <= RUN;
          end
        end
        RUN: begin
          for (int i = 0; i < NIBBLES; i++) begin
            if (idx == IW'(i)) sum_q[i] <= nib_s;
          end
          carry_q <= nib_co;
          idx     <= idx + 1'b1;
          if (idx == IW'(NIBBLES - 1)) begin
            cout      <= nib_co;
            res_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          if (res_ready) begin
            res_valid   <= 1'b0;
            start_ready <= 1'b1;
            state       <= IDLE;
          end
        end
        default: begin
          res_valid   <= 1'b0;
          start_ready <= 1'b1;
          state       <= IDLE;
        end
      endcase
    end
  end

  assign sum = sum_q;

endmodule

// File: tb/tb_nibble_serial_add_ctrl.sv
// Directed bench for nibble_serial_add_ctrl (NIBBLES=4 and NIBBLES=1).
// Subtract vectors run only when NSA_SUB_EN is defined.
module tb_nibble_serial_add_ctrl;

  logic clk = 1'b0;
  logic rst_n;

  logic        sv4, sr4, cin4, rv4, rr4, co4;
  logic [15:0] a4, b4, s4;
  logic        sub4;

  logic        sv1, sr1, cin1, rv1, rr1, co1;
  logic [3:0]  a1, b1, s1;
  logic        sub1;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  nibble_serial_add_ctrl #(.NIBBLES(4)) u_dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start_valid (sv4),
    .start_ready (sr4),
    .a           (a4),
    .b           (b4),
    .cin         (cin4),
`ifdef NSA_SUB_EN
    .sub         (sub4),
`endif
    .res_valid   (rv4),
    .res_ready   (rr4),
    .sum         (s4),
    .cout        (co4)
  );

  nibble_serial_add_ctrl #(.NIBBLES(1)) u_dut1 (
    .clk         (clk),
    .rst_n       (rst_n),
    .start_valid (sv1),
    .start_ready (sr1),
    .a           (a1),
    .b           (b1),
    .cin         (cin1),
`ifdef NSA_SUB_EN
    .sub         (sub1),
`endif
    .res_valid   (rv1),
    .res_ready   (rr1),
    .sum         (s1),
    .cout        (co1)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic run4(input logic [15:0] ta, input logic [15:0] tb_,
                      input logic tc, output logic [15:0] s,
                      output logic c, output int lat);
    @(negedge clk);
    chk("sr_before", sr4, 1'b1);
    sv4 = 1'b1; a4 = ta; b4 = tb_; cin4 = tc; rr4 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    sv4 = 1'b0; a4 = ~ta; b4 = ~tb_; cin4 = ~tc;
    lat = 0;
    while (!rv4 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    chk("no_timeout", lat < 20, 1'b1);
    s = s4;
    c = co4;
    @(posedge clk);
    @(negedge clk);
    chk("sr_after", {sr4, rv4}, 2'b10);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [15:0] s;
    logic        c;
    int          lat;
    int          last;
    int          acc_n;

    rst_n = 1'b0;
    sv4 = 0; a4 = 0; b4 = 0; cin4 = 0; rr4 = 0; sub4 = 0;
    sv1 = 0; a1 = 0; b1 = 0; cin1 = 0; rr1 = 0; sub1 = 0;
    #12;
    chk("rst_sum", s4, 16'h0000);
    chk("rst_flags", {co4, rv4, sr4}, 3'b001);
    @(negedge clk);
    rst_n = 1'b1;

    run4(16'h0008, 16'h0009, 1'b0, s, c, lat);
    chk("add1_sum", s, 16'h0011);
    chk("add1_cout", c, 1'b0);
    chk("add1_lat", lat, 4);

    run4(16'hFFFF, 16'h0001, 1'b0, s, c, lat);
    chk("wrap_sum", s, 16'h0000);
    chk("wrap_cout", c, 1'b1);

    run4(16'h0008, 16'h0007, 1'b1, s, c, lat);
    chk("cin_sum", s, 16'h0010);
    chk("cin_cout", c, 1'b0);

    run4(16'h8000, 16'h8001, 1'b1, s, c, lat);
    chk("msb_sum", s, 16'h0002);
    chk("msb_cout", c, 1'b1);

    // backpressure
    @(negedge clk);
    sv4 = 1'b1; a4 = 16'h00AB; b4 = 16'h0011; cin4 = 1'b0; rr4 = 1'b0;
    @(posedge clk);
    @(negedge clk);
    sv4 = 1'b0;
    lat = 0;
    while (!rv4 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    chk("bp_lat", lat, 4);
    for (int i = 0; i < 5; i++) begin
      chk("bp_sum", s4, 16'h00BC);
      chk("bp_flags", {co4, rv4, sr4}, 3'b010);
      if (i == 1) begin
        sv4 = 1'b1; a4 = 16'hFFFF; b4 = 16'hFFFF;
      end else begin
        sv4 = 1'b0;
      end
      @(negedge clk);
    end
    rr4 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("bp_release", {sr4, rv4}, 2'b10);
    @(negedge clk);
    chk("bp_not_queued", {sr4, rv4}, 2'b10);

    // reset mid-run
    sv4 = 1'b1; a4 = 16'h5555; b4 = 16'h2222; cin4 = 1'b0;
    @(posedge clk);
    @(negedge clk);
    sv4 = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("partial_sum", s4, 16'h0077);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_sum", s4, 16'h0000);
    chk("mid_rst_flags", {co4, rv4, sr4}, 3'b001);
    @(negedge clk);
    rst_n = 1'b1;
    run4(16'h1234, 16'h1111, 1'b0, s, c, lat);
    chk("post_rst_sum", s, 16'h2345);
    chk("post_rst_cout", c, 1'b0);

`ifdef NSA_SUB_EN
    sub4 = 1'b1;
    run4(16'h0005, 16'h0008, 1'b0, s, c, lat);
    chk("sub_neg_sum", s, 16'hFFFD);
    chk("sub_neg_cout", c, 1'b0);
    run4(16'h0008, 16'h0005, 1'b0, s, c, lat);
    chk("sub_pos_sum", s, 16'h0003);
    chk("sub_pos_cout", c, 1'b1);
    sub4 = 1'b0;
    run4(16'h0008, 16'h0005, 1'b0, s, c, lat);
    chk("sub_off_sum", s, 16'h000D);
`endif

    // NIBBLES=1, back-to-back issue
    @(negedge clk);
    sv1 = 1'b1; a1 = 4'h8; b1 = 4'h9; cin1 = 1'b0; rr1 = 1'b1;
    last  = -1;
    acc_n = 0;
    for (int cyc = 0; cyc < 12; cyc++) begin
      if (rv1) begin
        chk("n1_sum", s1, 4'h1);
        chk("n1_cout", co1, 1'b1);
        chk("n1_lat", cyc - last - 1, 1);
      end
      if (sr1) begin
        if (last >= 0) chk("n1_gap", cyc - last, 3);
        last = cyc;
        acc_n++;
      end
      @(negedge clk);
    end
    sv1 = 1'b0;
    chk("n1_accepts", acc_n >= 3, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
